// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the TX arbiter and the RX SIPO/deframer.
// Holds the TX arbiter state encoding, default payload width and frame constants.
package uart_pkg;

  // TX arbiter states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_arb_state_t;

  // Default payload width per request
  localparam int unsigned DATA_W_DEFAULT = 8;

  // Frame layout shared with the SIPO/deframer
  localparam int unsigned UART_START_BITS = 1;
  localparam int unsigned UART_STOP_BITS  = 1;
  localparam int unsigned UART_FRAME_BITS = UART_START_BITS + DATA_W_DEFAULT + UART_STOP_BITS;
  localparam logic        UART_START_LVL  = 1'b0;
  localparam logic        UART_STOP_LVL   = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the TX arbiter.
//   req/req_data       : requester levels and packed payloads (into arbiter)
//   grant              : one-hot accept pulse (out of arbiter)
//   tx_start/tx_data   : launch strobe and payload to the transmitter
//   tx_busy/tx_done    : transmitter handshake (into arbiter)
//   owner/active/timeout_err : status
// master = arbiter side, slave = environment side.
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = DATA_W_DEFAULT
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        grant;
  logic                    tx_start;
  logic [DATA_W-1:0]       tx_data;
  logic                    tx_busy;
  logic                    tx_done;
  logic [IDX_W-1:0]        owner;
  logic                    active;
  logic                    timeout_err;

  modport master (
    input  req, req_data, tx_busy, tx_done,
    output grant, tx_start, tx_data, owner, active, timeout_err
  );

  modport slave (
    output req, req_data, tx_busy, tx_done,
    input  grant, tx_start, tx_data, owner, active, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i   : request vector
//   last_i  : index served last; search starts at last_i+1 (mod N_REQ)
//   grant_c : one-hot of the selected request
//   idx_c   : index of the selected request
//   any_c   : at least one request present
module rr_pick #(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req_i,
  input  logic [$clog2(N_REQ)-1:0] last_i,
  output logic [N_REQ-1:0]         grant_c,
  output logic [$clog2(N_REQ)-1:0] idx_c,
  output logic                     any_c
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] cand;

  // Scan farthest-to-nearest so the nearest set bit after last_i wins.
  always_comb begin
    cand    = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    grant_c = '0;
    for (int k = int'(N_REQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last_i) + k) % int'(N_REQ));
      if (req_i[cand]) begin
        idx_c = cand;
        any_c = 1'b1;
      end
    end
    if (any_c) grant_c = N_REQ'(1) << idx_c;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART TX path among N_REQ
// byte requesters, with a launch watchdog against a silent transmitter.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : uart_tx_arbiter_if.master (req/req_data in, grant out,
//              tx_start/tx_data out, tx_busy/tx_done in, owner/active/timeout_err out)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned DATA_W  = DATA_W_DEFAULT,
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  tx_arb_state_t     state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic              start_q, start_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              err_q, err_d;

  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (bus.req),
    .last_i  (last_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .any_c   (pick_any)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      start_q  <= 1'b0;
      data_q   <= '0;
      owner_q  <= '0;
      last_q   <= IDX_W'(N_REQ - 1);
      cnt_q    <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      start_q  <= start_d;
      data_q   <= data_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  // Next state; strobes are computed one cycle ahead so every output is a flop.
  always_comb begin
    state_d = state_q;
    grant_d = '0;
    start_d = 1'b0;
    data_d  = data_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          data_d  = bus.req_data[int'(pick_idx) * int'(DATA_W) +: DATA_W];
          grant_d = pick_grant;
          start_d = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        last_d  = owner_q;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // done has priority so a busy-less transmitter still completes
        if (bus.tx_done) begin
          state_d = IDLE;
        end else if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (bus.tx_done || !bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d != IDLE);
  end

  assign bus.grant       = grant_q;
  assign bus.tx_start    = start_q;
  assign bus.tx_data     = data_q;
  assign bus.owner       = owner_q;
  assign bus.active      = active_q;
  assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: scoreboard of pending payloads, round-robin
// reference model, randomized transmitter behaviour plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;

  localparam int MODE_RAND  = 0;
  localparam int MODE_HANG  = 1;
  localparam int MODE_FIXED = 2;
  localparam int MODE_FAST  = 3;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.N_REQ(N), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  item_t         sb[$];
  int            win_log[$];
  int            model_last = N - 1;
  logic [N-1:0]  prev_req = '0;
  bit            prev_err = 1'b0;
  logic [DW-1:0] cur_data = '0;
  int            cyc = 0;
  int            start_cyc = 0;
  int            n_start = 0;
  int            n_done = 0;
  int            n_err = 0;
  int            tx_mode = MODE_RAND;
  int            fix_d = 0;
  int            fix_l = 1;
  bit            hold = 1'b0;
  bit            rand_raise = 1'b0;
  int            raise_budget = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Reference rule: first set request searching upward from last+1, modulo N.
  function automatic int rr_expect(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (last + k) % int'(N);
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Monitor: pops the scoreboard whenever a launch is presented.
  always @(negedge clk) begin
    if (rst) begin
      model_last = N - 1;
      prev_req   = '0;
      prev_err   = 1'b0;
    end else begin
      if (bus.tx_start) begin
        int w;
        int pos;
        w = rr_expect(prev_req, model_last);
        check("start_has_req", 32'(w >= 0), 32'd1);
        check("start_while_busy", 32'(bus.tx_busy), 32'd0);
        if (w >= 0) begin
          check("grant_onehot", 32'(bus.grant), 32'd1 << w);
          check("owner", 32'(bus.owner), 32'(w));
          pos = -1;
          foreach (sb[k]) if (pos < 0 && sb[k].idx == w) pos = k;
          check("sb_has_entry", 32'(pos >= 0), 32'd1);
          if (pos >= 0) begin
            check("tx_data", 32'(bus.tx_data), 32'(sb[pos].data));
            sb.delete(pos);
          end
          model_last = w;
          win_log.push_back(w);
        end
        cur_data  = bus.tx_data;
        start_cyc = cyc;
        n_start++;
      end else begin
        check("grant_no_start", 32'(bus.grant), 32'd0);
        if (bus.active) check("data_stable", 32'(bus.tx_data), 32'(cur_data));
      end
      if (bus.tx_done) n_done++;
      if (bus.timeout_err) begin
        n_err++;
        check("wd_expected", 32'(tx_mode == MODE_HANG), 32'd1);
        // TIMEOUT cycles in WAIT_BUSY after the launch cycle, then the registered pulse
        check("wd_latency", 32'(cyc - start_cyc), 32'(TO + 1));
        check("wd_active", 32'(bus.active), 32'd0);
      end
      if (prev_err) check("wd_pulse_width", 32'(bus.timeout_err), 32'd0);
      prev_err = bus.timeout_err;
      prev_req = bus.req;
    end
  end

  // Transmitter model reacting to each launch strobe.
  initial begin
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_start) begin
        int kind;
        int d;
        int l;
        kind = 0;
        d    = fix_d;
        l    = fix_l;
        case (tx_mode)
          MODE_HANG:  kind = 4;
          MODE_FAST:  kind = 1;
          MODE_FIXED: kind = 0;
          default: begin
            kind = int'($urandom_range(0, 3));
            d    = int'($urandom_range(0, 3));
            l    = int'($urandom_range(1, 6));
          end
        endcase
        @(posedge clk); #1;
        if (kind == 1) begin
          bus.tx_done = 1'b1;
          @(posedge clk); #1;
          bus.tx_done = 1'b0;
        end else if (kind == 3) begin
          bus.tx_busy = 1'b1;
          bus.tx_done = 1'b1;
          @(posedge clk); #1;
          bus.tx_busy = 1'b0;
          bus.tx_done = 1'b0;
        end else if (kind != 4) begin
          repeat (d) begin @(posedge clk); #1; end
          bus.tx_busy = 1'b1;
          repeat (l) begin @(posedge clk); #1; end
          bus.tx_busy = 1'b0;
          bus.tx_done = (kind == 0);
          @(posedge clk); #1;
          bus.tx_done = 1'b0;
        end
      end
    end
  end

  task automatic raise(input int i, input logic [DW-1:0] d);
    item_t it;
    bus.req_data[i*DW +: DW] = d;
    bus.req[i] = 1'b1;
    it.idx  = i;
    it.data = d;
    sb.push_back(it);
  endtask

  // One clock of requester behaviour: drop on grant, optionally re-raise.
  task automatic tick();
    @(posedge clk); #1;
    for (int i = 0; i < int'(N); i++) begin
      if (bus.req[i] && bus.grant[i]) begin
        bus.req[i] = 1'b0;
        if (hold) raise(i, DW'($urandom));
      end else if (!bus.req[i] && rand_raise && raise_budget > 0 && $urandom_range(0, 3) == 0) begin
        raise(i, DW'($urandom));
        raise_budget--;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      tick();
      @(negedge clk); #1;
      if (bus.req == '0 && !bus.active && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},    32'(bus.grant),       32'd0);
    check({tag, "_tx_start"}, 32'(bus.tx_start),    32'd0);
    check({tag, "_tx_data"},  32'(bus.tx_data),     32'd0);
    check({tag, "_owner"},    32'(bus.owner),       32'd0);
    check({tag, "_active"},   32'(bus.active),      32'd0);
    check({tag, "_err"},      32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    int exp_order[5];
    int n;
    int e0;
    int s0;
    int sz;
    exp_order = '{0, 1, 2, 3, 0};
    bus.req      = '0;
    bus.req_data = '0;

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Fairness: all four held, fixed 10-cycle frames
    tx_mode = MODE_FIXED; fix_d = 0; fix_l = 9;
    hold = 1'b1;
    win_log.delete();
    n_start = 0; n_done = 0;
    for (int i = 0; i < int'(N); i++) raise(i, DW'($urandom));
    n = 0;
    while (win_log.size() < 5 && n < 400) begin tick(); n++; end
    hold = 1'b0;
    wait_drain("fair_drain", 400);
    check("fair_count", 32'(win_log.size() >= 5), 32'd1);
    if (win_log.size() >= 5)
      for (int k = 0; k < 5; k++) check($sformatf("fair_order_%0d", k), 32'(win_log[k]), 32'(exp_order[k]));
    check("fair_start_per_frame", 32'(n_start), 32'(n_done));

    // Single request from requester 2
    tx_mode = MODE_FIXED; fix_d = 2; fix_l = 4;
    raise(2, 8'hA5);
    wait_drain("single_drain", 100);
    check("single_owner", 32'(bus.owner), 32'd2);
    check("single_data", 32'(bus.tx_data), 32'hA5);

    // Watchdog: silent transmitter
    tx_mode = MODE_HANG;
    e0 = n_err;
    raise(0, 8'h5A);
    n = 0;
    while (n_err == e0 && n < int'(TO) + 20) begin tick(); n++; end
    check("wd_fired", 32'(n_err - e0), 32'd1);
    tx_mode = MODE_FIXED; fix_d = 0; fix_l = 3;
    wait_drain("wd_drain", 50);
    s0 = n_start;
    raise(1, 8'hC3);
    wait_drain("wd_recover_drain", 100);
    check("wd_recover_start", 32'(n_start - s0), 32'd1);

    // Fast transmitter: done right after start, last must move to 3
    tx_mode = MODE_FAST;
    raise(3, 8'h96);
    wait_drain("fast_drain", 50);
    sz = win_log.size();
    raise(0, 8'h11);
    raise(3, 8'h33);
    wait_drain("fast_pair_drain", 100);
    check("fast_pair_count", 32'(win_log.size() - sz), 32'd2);
    if (win_log.size() >= sz + 2) begin
      check("fast_last_first", 32'(win_log[sz]), 32'd0);
      check("fast_last_second", 32'(win_log[sz+1]), 32'd3);
    end

    // Request withdrawn after capture
    tx_mode = MODE_FIXED; fix_d = 1; fix_l = 3;
    raise(1, 8'h4E);
    tick();
    bus.req[1] = 1'b0;
    @(negedge clk);
    check("withdraw_grant", 32'(bus.grant), 32'h2);
    wait_drain("withdraw_drain", 100);

    // Reset while in WAIT_DONE
    tx_mode = MODE_FIXED; fix_d = 0; fix_l = 12;
    raise(2, 8'h3C);
    repeat (4) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    bus.req = '0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    tx_mode = MODE_FIXED; fix_d = 0; fix_l = 2;
    sz = win_log.size();
    raise(0, 8'h81);
    raise(3, 8'h18);
    wait_drain("rst_drain", 100);
    check("rst_pair_count", 32'(win_log.size() - sz), 32'd2);
    if (win_log.size() > sz) check("rst_first_winner", 32'(win_log[sz]), 32'd0);

    // Randomized traffic with random transmitter behaviour
    tx_mode = MODE_RAND;
    e0 = n_err;
    rand_raise = 1'b1;
    raise_budget = 80;
    repeat (600) tick();
    rand_raise = 1'b0;
    wait_drain("rand_drain", 2000);
    check("rand_no_timeout", 32'(n_err - e0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished cycle=%0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
